// File: rtl/rpn_stack_calc_p.sv
// Parametrised RPN stack calculator: top-of-stack in a register, deeper entries in an array.
// One operation per step edge (latency 1, never busy); bad pushes/ops leave state intact and raise a sticky error.
module rpn_stack_calc_p #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 1024,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             step,
   input  logic             nrst,
   input  logic             en,
   input  logic             push,
   input  logic [WIDTH-1:0] d,
   input  logic [2:0]       op,
   input  logic             clr_err,
   output logic [WIDTH-1:0] out,
   output logic [CW-1:0]    cnt,
   output logic             err,
   output logic [1:0]       err_code
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] E_UNDER = 2'b01;
   localparam logic [1:0] E_OVER  = 2'b10;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_NEG  = 3'd1,
      OP_ADD  = 3'd2,
      OP_MUL  = 3'd3,
      OP_SUB  = 3'd4,
      OP_SWAP = 3'd5,
      OP_DUP  = 3'd6,
      OP_DROP = 3'd7
   } op_e;

   logic [WIDTH-1:0] t_q, t_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;

   logic [WIDTH-1:0] mem_q [2**AW];
   logic             mem_we;
   logic [AW-1:0]    mem_wa;
   logic [WIDTH-1:0] mem_wd;

   logic [AW-1:0]    s_addr;
   logic [WIDTH-1:0] s_dat;
   logic             has1, has2, full;
   logic             rej;
   logic [1:0]       rej_code;

   assign s_addr = AW'(cnt_q - CW'(2));
   assign s_dat  = mem_q[s_addr];
   assign has1   = (cnt_q >= CW'(1));
   assign has2   = (cnt_q >= CW'(2));
   assign full   = (cnt_q == CW'(DEPTH));

   always_comb begin
      t_d        = t_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      mem_we     = 1'b0;
      mem_wa     = AW'(cnt_q - CW'(1));
      mem_wd     = t_q;
      rej        = 1'b0;
      rej_code   = E_UNDER;
      if (en) begin
         if (clr_err) begin
            err_d      = 1'b0;
            err_code_d = 2'b00;
         end
         if (push) begin
            if (!full) begin
               mem_we = has1;
               t_d    = d;
               cnt_d  = cnt_q + CW'(1);
            end else begin
               rej      = 1'b1;
               rej_code = E_OVER;
            end
         end else begin
            case (op_e'(op))
               OP_NOP: begin
               end
               OP_NEG: begin
                  if (has1) t_d = '0 - t_q;
                  else      rej = 1'b1;
               end
               OP_ADD, OP_MUL, OP_SUB: begin
                  if (has2) begin
                     cnt_d = cnt_q - CW'(1);
                     if (op_e'(op) == OP_ADD)      t_d = s_dat + t_q;
                     else if (op_e'(op) == OP_MUL) t_d = s_dat * t_q;
                     else                          t_d = s_dat - t_q;
                  end else begin
                     rej = 1'b1;
                  end
               end
               OP_SWAP: begin
                  if (has2) begin
                     t_d    = s_dat;
                     mem_we = 1'b1;
                     mem_wa = s_addr;
                  end else begin
                     rej = 1'b1;
                  end
               end
               OP_DUP: begin
                  if (!has1) begin
                     rej = 1'b1;
                  end else if (full) begin
                     rej      = 1'b1;
                     rej_code = E_OVER;
                  end else begin
                     mem_we = 1'b1;
                     cnt_d  = cnt_q + CW'(1);
                  end
               end
               OP_DROP: begin
                  if (has1) begin
                     t_d   = has2 ? s_dat : '0;
                     cnt_d = cnt_q - CW'(1);
                  end else begin
                     rej = 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
         // err_d already reflects clr_err, so a same-cycle error overrides the clear
         if (rej && !err_d) begin
            err_d      = 1'b1;
            err_code_d = rej_code;
         end
      end
   end

   always_ff @(posedge step or negedge nrst) begin
      if (!nrst) begin
         t_q        <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         t_q        <= t_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   always_ff @(posedge step) begin
      if (mem_we && nrst) mem_q[mem_wa] <= mem_wd;
   end

   assign out      = t_q;
   assign cnt      = cnt_q;
   assign err      = err_q;
   assign err_code = err_code_q;

endmodule
